// File: rtl/vfpu_dc_pkg.sv
// Shared types and defaults for the VFPU operand bridge.
package vfpu_dc_pkg;

  localparam int VFPU_DW_DEF           = 32;
  localparam int VFPU_BRIDGE_DEPTH_DEF = 8;

  typedef bit [VFPU_DW_DEF-1:0] vfpu_word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } bridge_st_e;

endpackage

// File: rtl/vfpu_res_fifo.sv
// Synchronous result FIFO with combinational head read and a synchronous clear.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module vfpu_res_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         pop,
  output logic [DW-1:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (clr) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

  // Storage array, zeroed on reset so the head output reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {DW{1'b0}};
    end else if (push_ok && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/vfpu_op_bridge.sv
// Operand-issue / result-collect bridge between the test-side stream and the VFPU core.
// Optional feature macro: VFPU_BRIDGE_TAG_EN adds res_tag, a per-op issue sequence tag.
module vfpu_op_bridge
  import vfpu_dc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = VFPU_BRIDGE_DEPTH_DEF,
  parameter int TW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_vld,
  output logic           op_rdy,
  input  logic [DW-1:0]  operand_a,
  input  logic [DW-1:0]  operand_b,
  input  logic [DW-1:0]  operand_c,
  output logic           op_vld_rx,
  output logic [DW-1:0]  operand_a_rx,
  output logic [DW-1:0]  operand_b_rx,
  output logic [DW-1:0]  operand_c_rx,
  output logic           core_vld,
  output logic [DW-1:0]  core_a,
  output logic [DW-1:0]  core_b,
  output logic [DW-1:0]  core_c,
  input  logic [DW-1:0]  core_res,
  input  logic           core_res_vld,
  output logic [DW-1:0]  res,
  output logic           res_rdy,
  input  logic           res_ack,
  input  logic           flush,
  output logic           busy,
  output logic           ovf
`ifdef VFPU_BRIDGE_TAG_EN
  ,
  output logic [TW-1:0]  res_tag
`endif
);

  localparam int CW = $clog2(DEPTH+1);
`ifdef VFPU_BRIDGE_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int FW = DW + (TAG_EN ? TW : 0);

  bridge_st_e    state;
  bridge_st_e    state_nxt;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          rdy_en;
  logic          accept;
  logic          res_push;
  logic          res_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;

  // Credit: results in flight plus results buffered may never exceed DEPTH.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign op_rdy      = rdy_en & (state == RUN) & (credit_used < (CW+1)'(DEPTH));
  assign accept      = op_vld & op_rdy;
  // Results with nothing in flight are strays (e.g. issued before a reset).
  assign res_push    = core_res_vld & (in_flight != {CW{1'b0}});
  assign res_rdy     = ~fifo_empty & (state != CLEAR);
  assign res_pop     = res_rdy & res_ack;
  assign busy        = (in_flight != {CW{1'b0}}) | (state != RUN);
  assign res         = fifo_rdata[DW-1:0];

  // The echo shares the issue register: both show the triple captured last cycle.
  assign op_vld_rx    = core_vld;
  assign operand_a_rx = core_a;
  assign operand_b_rx = core_b;
  assign operand_c_rx = core_c;

  // Holds op_rdy low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Issue register: strobe for one cycle per accepted triple, data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_vld <= 1'b0;
      core_a   <= {DW{1'b0}};
      core_b   <= {DW{1'b0}};
      core_c   <= {DW{1'b0}};
    end else begin
      core_vld <= accept;
      if (accept) begin
        core_a <= operand_a;
        core_b <= operand_b;
        core_c <= operand_c;
      end
    end
  end

  // In-flight counter: up on accept, down on a counted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= {CW{1'b0}};
    end else begin
      case ({accept, res_push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky overflow when a counted result finds the FIFO full with no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf <= 1'b0;
    else if (res_push && fifo_full && !res_pop) ovf <= 1'b1;
  end

  // Flush state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Flush sequencing: stop accepting, wait for the core to drain, then clear once.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
               else       state_nxt = RUN;
      DRAIN:   if (in_flight == {CW{1'b0}}) state_nxt = CLEAR;
               else                         state_nxt = DRAIN;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef VFPU_BRIDGE_TAG_EN
  localparam int AW = $clog2(DEPTH);

  logic [TW-1:0] tag_cnt;
  logic [TW-1:0] tag_mem [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  // Issue counter and tag shadow pointers; the shadow follows in-flight order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= {TW{1'b0}};
      tag_wr  <= {AW{1'b0}};
      tag_rd  <= {AW{1'b0}};
    end else if (state == CLEAR) begin
      tag_cnt <= {TW{1'b0}};
      tag_wr  <= {AW{1'b0}};
      tag_rd  <= {AW{1'b0}};
    end else begin
      if (accept) begin
        tag_cnt <= tag_cnt + TW'(1);
        tag_wr  <= tag_wr + AW'(1);
      end
      if (res_push) tag_rd <= tag_rd + AW'(1);
    end
  end

  // Tag shadow storage, written with the tag of each accepted triple.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= tag_cnt;
  end

  assign fifo_wdata = {tag_mem[tag_rd], core_res};
  assign res_tag    = fifo_rdata[FW-1:DW];
`else
  assign fifo_wdata = core_res;
`endif

  vfpu_res_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == CLEAR),
    .push  (res_push),
    .wdata (fifo_wdata),
    .pop   (res_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_vfpu_op_bridge.sv
// Scoreboard bench for vfpu_op_bridge: DEPTH=8 instance with a model core,
// plus a DEPTH=4 instance driven by hand for the credit back-pressure case.
module tb_vfpu_op_bridge;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // main instance (DEPTH=8)
  logic          op_vld, op_rdy, op_vld_rx, core_vld, res_rdy, res_ack, flush, busy, ovf;
  logic [DW-1:0] operand_a, operand_b, operand_c;
  logic [DW-1:0] operand_a_rx, operand_b_rx, operand_c_rx;
  logic [DW-1:0] core_a, core_b, core_c, res;
  logic [DW-1:0] core_res = '0;
  logic          core_res_vld = 1'b0;
  logic          core_hold;
`ifdef VFPU_BRIDGE_TAG_EN
  logic [1:0]    res_tag;
`endif

  // back-pressure instance (DEPTH=4)
  logic          b_op_vld, b_op_rdy, b_op_vld_rx, b_core_vld, b_res_rdy, b_res_ack, b_flush, b_busy, b_ovf;
  logic          b_core_res_vld;
  logic [DW-1:0] b_operand_a, b_operand_b, b_operand_c;
  logic [DW-1:0] b_operand_a_rx, b_operand_b_rx, b_operand_c_rx;
  logic [DW-1:0] b_core_a, b_core_b, b_core_c, b_core_res, b_res;
`ifdef VFPU_BRIDGE_TAG_EN
  logic [3:0]    b_res_tag;
`endif

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] b_exp_q[$];
  logic [DW-1:0] pend_d[$];
  int            pend_t[$];

  vfpu_op_bridge #(.DW(DW), .DEPTH(8), .TW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy),
    .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
    .op_vld_rx(op_vld_rx), .operand_a_rx(operand_a_rx), .operand_b_rx(operand_b_rx),
    .operand_c_rx(operand_c_rx), .core_vld(core_vld), .core_a(core_a), .core_b(core_b),
    .core_c(core_c), .core_res(core_res), .core_res_vld(core_res_vld), .res(res),
    .res_rdy(res_rdy), .res_ack(res_ack), .flush(flush), .busy(busy), .ovf(ovf)
`ifdef VFPU_BRIDGE_TAG_EN
    , .res_tag(res_tag)
`endif
  );

  vfpu_op_bridge #(.DW(DW), .DEPTH(4), .TW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op_vld(b_op_vld), .op_rdy(b_op_rdy),
    .operand_a(b_operand_a), .operand_b(b_operand_b), .operand_c(b_operand_c),
    .op_vld_rx(b_op_vld_rx), .operand_a_rx(b_operand_a_rx), .operand_b_rx(b_operand_b_rx),
    .operand_c_rx(b_operand_c_rx), .core_vld(b_core_vld), .core_a(b_core_a), .core_b(b_core_b),
    .core_c(b_core_c), .core_res(b_core_res), .core_res_vld(b_core_res_vld), .res(b_res),
    .res_rdy(b_res_rdy), .res_ack(b_res_ack), .flush(b_flush), .busy(b_busy), .ovf(b_ovf)
`ifdef VFPU_BRIDGE_TAG_EN
    , .res_tag(b_res_tag)
`endif
  );

  // Model core operation: the fixed FP vector 1.0+2.0+0.0, otherwise an integer sum.
  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, b, c);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h0000_0000) return 32'h4040_0000;
    return a + b + c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model core: in-order results a few cycles after issue; core_hold stalls returns.
  always @(posedge clk) begin
    if (core_vld === 1'b1) begin
      pend_d.push_back(core_fn(core_a, core_b, core_c));
      pend_t.push_back(cyc + 3);
    end
    if (!core_hold && pend_d.size() > 0 && pend_t[0] <= cyc) begin
      core_res     <= pend_d.pop_front();
      core_res_vld <= 1'b1;
      void'(pend_t.pop_front());
    end else begin
      core_res_vld <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits until the model core and the bridge are idle with results buffered.
  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      if (pend_d.size() == 0 && core_res_vld === 1'b0 && busy === 1'b0) break;
      tick;
    end
    n_vec++;
    if (i >= 40) begin n_err++; $display("FAIL %s_idle_timeout: bridge still busy=%b", tag, busy); end
  endtask

  task automatic test_reset;
    int late;
    rst_n = 1'b0; op_vld = 1'b0; res_ack = 1'b0; flush = 1'b0; core_hold = 1'b0;
    operand_a = '0; operand_b = '0; operand_c = '0;
    b_op_vld = 1'b0; b_res_ack = 1'b0; b_flush = 1'b0; b_core_res_vld = 1'b0;
    b_operand_a = '0; b_operand_b = '0; b_operand_c = '0; b_core_res = '0;
    repeat (2) tick;
    n_vec++;
    if ({op_rdy, op_vld_rx, core_vld, res_rdy, busy, ovf} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000", {op_rdy, op_vld_rx, core_vld, res_rdy, busy, ovf});
    end
    n_vec++;
    if ({core_a, core_b, core_c, operand_a_rx, operand_b_rx, operand_c_rx, res} !== '0) begin
      n_err++; $display("FAIL reset_buses: core_a=%h echo_a=%h res=%h expected 0", core_a, operand_a_rx, res);
    end
    rst_n = 1'b1;
    n_vec++;
    if (op_rdy !== 1'b0) begin n_err++; $display("FAIL rdy_at_release: got %b expected 0", op_rdy); end
    tick;
    n_vec++;
    if (op_rdy !== 1'b1) begin n_err++; $display("FAIL rdy_after_release: got %b expected 1", op_rdy); end
    // three ops in flight, then reset mid-operation
    op_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      operand_a = 32'h50 + i; operand_b = 32'h1; operand_c = 32'h2;
      tick;
    end
    op_vld = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({core_vld, op_vld_rx, busy, op_rdy} !== 4'b0 || core_a !== '0) begin
      n_err++; $display("FAIL midreset_outputs: vld=%b busy=%b core_a=%h expected all 0", core_vld, busy, core_a);
    end
    tick;
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 20 && (pend_d.size() != 0 || core_res_vld === 1'b1); i++) begin
      if (core_res_vld === 1'b1) late++;
      tick;
    end
    tick;
    n_vec++;
    if (late == 0 || pend_d.size() != 0) begin n_err++; $display("FAIL late_core_returns: got %0d late results expected 3", late); end
    n_vec++;
    if ({res_rdy, busy, ovf, op_rdy} !== 4'b0001) begin
      n_err++; $display("FAIL stray_ignored: rdy/busy/ovf/op_rdy got %b expected 0001", {res_rdy, busy, ovf, op_rdy});
    end
  endtask

  task automatic test_single;
    logic [DW-1:0] exp;
    operand_a = 32'h3F80_0000; operand_b = 32'h4000_0000; operand_c = 32'h0;
    op_vld = 1'b1;
    n_vec++;
    if (op_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy: got %b expected 1", op_rdy); end
    exp_q.push_back(32'h4040_0000);
    tick;
    op_vld = 1'b0;
    n_vec++;
    if ({core_vld, core_a, core_b, core_c} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h0}) begin
      n_err++; $display("FAIL single_issue: got vld=%b %h %h %h expected 1 3f800000 40000000 0", core_vld, core_a, core_b, core_c);
    end
    n_vec++;
    if ({op_vld_rx, operand_a_rx, operand_b_rx, operand_c_rx} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h0}) begin
      n_err++; $display("FAIL single_echo: got vld=%b %h %h %h", op_vld_rx, operand_a_rx, operand_b_rx, operand_c_rx);
    end
    tick;
    n_vec++;
    if (core_vld !== 1'b0 || op_vld_rx !== 1'b0 || core_a !== 32'h3F80_0000) begin
      n_err++; $display("FAIL single_hold: vld=%b rx=%b core_a=%h expected 0 0 3f800000", core_vld, op_vld_rx, core_a);
    end
    for (int i = 0; i < 20 && res_rdy !== 1'b1; i++) tick;
    exp = exp_q.pop_front();
    n_vec++;
    if (res_rdy !== 1'b1 || res !== exp) begin n_err++; $display("FAIL single_result: rdy=%b res=%h expected 1 %h", res_rdy, res, exp); end
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;
    n_vec++;
    if (res_rdy !== 1'b0) begin n_err++; $display("FAIL single_pop: res_rdy=%b expected 0", res_rdy); end
  endtask

  task automatic test_concurrency;
    logic [DW-1:0] exp;
    op_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      operand_a = 32'h10 + i; operand_b = 32'h100; operand_c = 32'h1000;
      exp_q.push_back(core_fn(operand_a, operand_b, operand_c));
      tick;
    end
    op_vld = 1'b0;
    wait_idle("conc");
    core_hold = 1'b1;
    operand_a = 32'h12; op_vld = 1'b1;
    exp_q.push_back(core_fn(operand_a, operand_b, operand_c));
    tick;
    op_vld = 1'b0;
    for (int i = 0; i < 20 && !(pend_d.size() == 1 && pend_t[0] <= cyc); i++) tick;
    core_hold = 1'b0;
    tick;
    // result strobe now high: pop in the same cycle as the push (count stays 2)
    res_ack = 1'b1;
    exp = exp_q.pop_front();
    n_vec++;
    if (core_res_vld !== 1'b1 || res !== exp) begin n_err++; $display("FAIL conc_head: strobe=%b res=%h expected 1 %h", core_res_vld, res, exp); end
    tick;
    res_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (res_rdy !== 1'b1 || res !== exp) begin n_err++; $display("FAIL conc_order%0d: rdy=%b res=%h expected 1 %h", k, res_rdy, res, exp); end
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
    end
    n_vec++;
    if (res_rdy !== 1'b0) begin n_err++; $display("FAIL conc_count: res_rdy=%b expected 0 after two pops", res_rdy); end
  endtask

  task automatic test_flush;
    int nret;
    op_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      operand_a = 32'h20 + i; operand_b = 32'h0; operand_c = 32'h0;
      tick;
    end
    op_vld = 1'b0;
    wait_idle("flush");
    core_hold = 1'b1;
    op_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      operand_a = 32'h30 + i;
      flush = (i == 2);
      n_vec++;
      if (op_rdy !== 1'b1) begin n_err++; $display("FAIL flush_pre_rdy%0d: got %b expected 1", i, op_rdy); end
      tick;
    end
    op_vld = 1'b0; flush = 1'b0;
    n_vec++;
    if (core_vld !== 1'b1 || core_a !== 32'h32 || op_rdy !== 1'b0) begin
      n_err++; $display("FAIL flush_same_cycle_issue: vld=%b core_a=%h op_rdy=%b expected 1 00000032 0", core_vld, core_a, op_rdy);
    end
    nret = 0;
    for (int i = 0; i < 30 && nret < 3; i++) begin
      if (i == 3) core_hold = 1'b0;
      tick;
      n_vec++;
      if ({op_rdy, busy, res_rdy} !== 3'b011) begin
        n_err++; $display("FAIL flush_drain: op_rdy/busy/res_rdy got %b expected 011", {op_rdy, busy, res_rdy});
      end
      if (core_res_vld === 1'b1) nret++;
    end
    n_vec++;
    if (nret != 3) begin n_err++; $display("FAIL flush_timeout: got %0d returns expected 3", nret); end
    tick;
    n_vec++;
    if ({op_rdy, busy, res_rdy} !== 3'b011) begin n_err++; $display("FAIL flush_last_drain: got %b expected 011", {op_rdy, busy, res_rdy}); end
    tick;
    n_vec++;
    if ({op_rdy, busy, res_rdy} !== 3'b010) begin n_err++; $display("FAIL flush_clear: got %b expected 010", {op_rdy, busy, res_rdy}); end
    tick;
    n_vec++;
    if ({op_rdy, busy, res_rdy} !== 3'b100) begin n_err++; $display("FAIL flush_run: got %b expected 100", {op_rdy, busy, res_rdy}); end
    exp_q.delete();
  endtask

`ifdef VFPU_BRIDGE_TAG_EN
  task automatic test_tag;
    logic [1:0]    tag_q[$];
    logic [1:0]    etag;
    logic [DW-1:0] exp;
    op_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      operand_a = 32'h40 + i; operand_b = 32'h7; operand_c = 32'h0;
      exp_q.push_back(core_fn(operand_a, operand_b, operand_c));
      tag_q.push_back(2'(i));
      tick;
    end
    op_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 20 && res_rdy !== 1'b1; i++) tick;
      exp = exp_q.pop_front();
      etag = tag_q.pop_front();
      n_vec++;
      if (res_rdy !== 1'b1 || res !== exp || res_tag !== etag) begin
        n_err++; $display("FAIL tag%0d: rdy=%b res=%h tag=%0d expected 1 %h %0d", k, res_rdy, res, res_tag, exp, etag);
      end
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
    end
  endtask
`endif

  task automatic test_back_to_back;
    int acc;
    logic [DW-1:0] exp;
    acc = 0;
    b_op_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_operand_a = 32'h100 + i;
      if (b_op_rdy === 1'b1) acc++;
      tick;
    end
    b_op_vld = 1'b0;
    n_vec++;
    if (acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    n_vec++;
    if ({b_op_rdy, b_ovf} !== 2'b00) begin n_err++; $display("FAIL bp_full_credit: op_rdy/ovf got %b expected 00", {b_op_rdy, b_ovf}); end
    for (int i = 0; i < 4; i++) begin
      b_core_res = 32'hA0 + i; b_core_res_vld = 1'b1;
      b_exp_q.push_back(b_core_res);
      tick;
    end
    b_core_res = 32'hEE; // stray: nothing in flight
    tick;
    b_core_res_vld = 1'b0;
    exp = b_exp_q.pop_front();
    n_vec++;
    if ({b_res_rdy, b_op_rdy, b_ovf} !== 3'b100 || b_res !== exp) begin
      n_err++; $display("FAIL bp_buffered: rdy/op_rdy/ovf=%b res=%h expected 100 %h", {b_res_rdy, b_op_rdy, b_ovf}, b_res, exp);
    end
    b_res_ack = 1'b1;
    n_vec++;
    if (b_op_rdy !== 1'b0) begin n_err++; $display("FAIL bp_same_cycle_pop: op_rdy=%b expected 0", b_op_rdy); end
    tick;
    b_res_ack = 1'b0;
    exp = b_exp_q.pop_front();
    n_vec++;
    if (b_op_rdy !== 1'b1 || b_res !== exp) begin n_err++; $display("FAIL bp_credit_return: op_rdy=%b res=%h expected 1 %h", b_op_rdy, b_res, exp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_concurrency();
    test_flush();
`ifdef VFPU_BRIDGE_TAG_EN
    test_tag();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
